// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, WIDTH bounds
// and the bit-counter width helper.
package serial_sub_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter only has to index bits 0..WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: diff = a ^ b ^ b_in, borrow when a < b + b_in.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign diff  = w_axb ^ b_in;
    assign b_out = (~a & b) | (~w_axb & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first, one bit/clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be within 2..32");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             r_done;
    logic             r_busy;

    logic             w_accept;
    logic             w_last;
    logic             w_diff_bit;
    logic             w_borrow_next;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .b_in (r_borrow),
        .diff (w_diff_bit),
        .b_out(w_borrow_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == LAST_BIT) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands in diff[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a          <= a;
            r_b          <= b;
            r_borrow     <= borrow_in;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_diff   <= {w_diff_bit, r_diff[WIDTH-1:1]};
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_borrow_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_borrow_out <= w_borrow_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_overflow;

    // Operand MSBs are kept because the shift registers have lost them by DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= b[WIDTH-1];
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_overflow <= (r_a_msb != r_b_msb) && (w_diff_bit != r_a_msb);
        end
    end

    assign overflow = r_overflow;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) and full_subtractor;
// overflow checks are active when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W    = 8;
    localparam int          SMIN = -(1 << (W - 1));
    localparam int          SMAX = (1 << (W - 1)) - 1;

    logic         clk    = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf_obs;

    logic fs_a, fs_b, fs_bin, fs_d, fs_bo;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 if (clk_en) clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow  (ovf_obs)
`endif
    );

`ifndef SERIAL_SUB_OVERFLOW_EN
    assign ovf_obs = 1'b0;
`endif

    full_subtractor u_fs_ut (
        .a    (fs_a),
        .b    (fs_b),
        .b_in (fs_bin),
        .diff (fs_d),
        .b_out(fs_bo)
    );

    // Reference: plain integer subtraction, unsigned for borrow and signed for overflow.
    function automatic void ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rbin, output logic [W-1:0] rd,
                                    output logic rbo, output logic rov);
        int full, sa, sb, sd;
        full = int'(ra) - int'(rb) - int'(rbin);
        rbo  = (full < 0);
        rd   = full[W-1:0];
        sa   = int'($signed(ra));
        sb   = int'($signed(rb));
        sd   = sa - sb - int'(rbin);
        rov  = (sd < SMIN) || (sd > SMAX);
    endfunction

    // Drives one request and observes the bounded window that follows it.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                         output logic [W-1:0] od, output logic obo, output logic oov,
                         output int olat, output int ndone,
                         output logic busy_first, output logic busy_after);
        @(negedge clk);
        a = ta; b = tb_; borrow_in = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        olat = -1; ndone = 0; od = '0; obo = 1'b0; oov = 1'b0;
        busy_first = busy; busy_after = 1'b1;
        for (int c = 1; c <= int'(W) + 5; c++) begin
            if (c > 1) @(negedge clk);
            if (done) begin
                ndone++;
                olat = c;
                od = diff; obo = borrow_out; oov = ovf_obs;
            end
            if (olat > 0 && c == olat + 1) busy_after = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        #3;
        n_checks++;
        if ({busy, done, diff, borrow_out, ovf_obs} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ov=%b required all 0",
                     busy, done, diff, borrow_out, ovf_obs);
        else n_pass++;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0)
                $display("FAIL idle_no_start: cycle %0d got busy=%b done=%b required 0 0", i, busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_full_subtractor();
        logic [2:0] v;
        int r;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            fs_a = v[2]; fs_b = v[1]; fs_bin = v[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            n_checks++;
            if (fs_d !== r[0] || fs_bo !== (r < 0))
                $display("FAIL full_sub %b%b%b: got d=%b bo=%b required d=%b bo=%b",
                         fs_a, fs_b, fs_bin, fs_d, fs_bo, r[0], (r < 0));
            else n_pass++;
        end
    endtask

    task automatic test_timing();
        logic [W-1:0] d; logic bo, ov, bf, ba; int lat, nd;
        do_op(8'h05, 8'h03, 1'b0, d, bo, ov, lat, nd, bf, ba);
        n_checks++;
        if (bf !== 1'b1) $display("FAIL busy_after_start: got %b required 1", bf);
        else n_pass++;
        n_checks++;
        if (nd !== 1 || lat !== int'(W) + 1)
            $display("FAIL done_timing: got count=%0d at=%0d required count=1 at=%0d", nd, lat, W + 1);
        else n_pass++;
        n_checks++;
        if (d !== 8'h02 || bo !== 1'b0)
            $display("FAIL basic_result: got diff=%h bo=%b required 02 0", d, bo);
        else n_pass++;
        n_checks++;
        if (ba !== 1'b0) $display("FAIL busy_fall: got %b required 0", ba);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5]  = '{8'h05, 8'h00, 8'hFF, 8'h80, 8'h7F};
        logic [W-1:0] vb[5]  = '{8'h03, 8'h01, 8'hFF, 8'h01, 8'hFF};
        logic         vc[5]  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        logic [W-1:0] ed[5]  = '{8'h02, 8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic         eb[5]  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic         eo[5]  = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        logic [W-1:0] d; logic bo, ov, bf, ba; int lat, nd;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], d, bo, ov, lat, nd, bf, ba);
            n_checks++;
            if (nd !== 1 || d !== ed[i] || bo !== eb[i])
                $display("FAIL directed_%0d: got n=%0d diff=%h bo=%b required n=1 diff=%h bo=%b",
                         i, nd, d, bo, ed[i], eb[i]);
            else n_pass++;
`ifdef SERIAL_SUB_OVERFLOW_EN
            n_checks++;
            if (ov !== eo[i]) $display("FAIL overflow_%0d: got %b required %b", i, ov, eo[i]);
            else n_pass++;
`else
            if (ov !== 1'b0 && eo[i] === 1'b1) $display("ignored");
`endif
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb_, d, ed; logic tc, bo, ov, eb, eo, bf, ba; int lat, nd;
        for (int i = 0; i < 40; i++) begin
            ta = W'($urandom); tb_ = W'($urandom); tc = 1'($urandom);
            ref_sub(ta, tb_, tc, ed, eb, eo);
            do_op(ta, tb_, tc, d, bo, ov, lat, nd, bf, ba);
            n_checks++;
            if (nd !== 1 || lat !== int'(W) + 1 || d !== ed || bo !== eb)
                $display("FAIL random_%0d %h-%h-%b: got n=%0d at=%0d diff=%h bo=%b required n=1 at=%0d diff=%h bo=%b",
                         i, ta, tb_, tc, nd, lat, d, bo, W + 1, ed, eb);
            else n_pass++;
`ifdef SERIAL_SUB_OVERFLOW_EN
            n_checks++;
            if (ov !== eo) $display("FAIL random_ovf_%0d: got %b required %b", i, ov, eo);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_ignore_start();
        int nd = 0;
        logic [W-1:0] d = '0;
        @(negedge clk);
        a = 8'h10; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 2 * int'(W) + 6; c++) begin
            if (c > 1) @(negedge clk);
            if (done) begin nd++; d = diff; end
            if (c == 3 || c == int'(W) + 1) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (nd !== 1 || d !== 8'h0F)
            $display("FAIL ignore_start: got n=%0d diff=%h required n=1 diff=0f", nd, d);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ignore_start_idle: got busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] d; logic bo, ov, bf, ba; int lat, nd;
        @(negedge clk);
        a = 8'h3C; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, diff, borrow_out, ovf_obs} !== '0)
            $display("FAIL reset_midop: got busy=%b done=%b diff=%h bo=%b ov=%b required all 0",
                     busy, done, diff, borrow_out, ovf_obs);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h09, 8'h04, 1'b0, d, bo, ov, lat, nd, bf, ba);
        n_checks++;
        if (nd !== 1 || lat !== int'(W) + 1 || d !== 8'h05 || bo !== 1'b0)
            $display("FAIL after_reset_op: got n=%0d at=%0d diff=%h bo=%b required n=1 at=%0d diff=05 bo=0",
                     nd, lat, d, bo, W + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int times[$];
        logic [W-1:0] ed; logic eb, eo;
        ref_sub(8'hC3, 8'h5A, 1'b1, ed, eb, eo);
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; borrow_in = 1'b1; start = 1'b1;
        for (int c = 1; c <= 3 * (int'(W) + 2); c++) begin
            @(negedge clk);
            if (done) begin
                times.push_back(c);
                n_checks++;
                if (diff !== ed || borrow_out !== eb)
                    $display("FAIL b2b_result: got diff=%h bo=%b required %h %b", diff, borrow_out, ed, eb);
                else n_pass++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (times.size() !== 3)
            $display("FAIL b2b_count: got %0d required 3", times.size());
        else n_pass++;
        for (int i = 1; i < times.size(); i++) begin
            n_checks++;
            if (times[i] - times[i-1] !== int'(W) + 2)
                $display("FAIL b2b_period: got %0d required %0d", times[i] - times[i-1], W + 2);
            else n_pass++;
        end
        repeat (int'(W) + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_subtractor();
        test_timing();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
